// File: rtl/wb_arbiter_rr_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM state encoding.
package wb_arbiter_rr_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TERM  = 2'd2;

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Single-transfer Wishbone bundle for NM initiators; NM=1 gives a plain point-to-point port.
interface wb_arbiter_rr_if #(
  parameter int NM = 1,
  parameter int AW = 16,
  parameter int DW = 32
);

  logic [NM*AW-1:0]   addr;
  logic [NM*DW-1:0]   wdata;
  logic [NM*DW/8-1:0] wmsk;
  logic [NM-1:0]      we;
  logic [NM-1:0]      cyc;
  logic [NM-1:0]      ack;
  logic [DW-1:0]      rdata;

  modport master (
    output addr, wdata, wmsk, we, cyc,
    input  ack, rdata
  );

  modport slave (
    input  addr, wdata, wmsk, we, cyc,
    output ack, rdata
  );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational N-way rotating-priority picker: first requester at or after (ptr+1) mod N.
module arb_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // Scan from the farthest slot to the nearest so the nearest requester is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave between N masters, with a hung-cycle watchdog.
// Slave cyc follows a request by one cycle; acks pass through combinationally.
module wb_arbiter_rr
  import wb_arbiter_rr_pkg::*;
#(
  parameter int N    = 2,
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int TO_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_arbiter_rr_if.slave       m,
  wb_arbiter_rr_if.master      s,
  output logic                 timeout,
  input  logic                 clr_timeout,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);
  localparam int MW = DW / 8;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("wb_arbiter_rr: N must be in 2..8");
  end

  logic [1:0]      state;
  logic [IW-1:0]   ptr;
  logic [TO_W-1:0] wd;
  logic [TO_W-1:0] wd_inc;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            own_cyc;

  arb_rr_pick #(.N(N)) u_pick (
    .req   (m.cyc),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    s.addr  = m.addr[AW-1:0];
    s.wdata = m.wdata[DW-1:0];
    s.wmsk  = m.wmsk[MW-1:0];
    s.we    = m.we[0];
    own_cyc = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == IW'(i)) begin
        s.addr  = m.addr[i*AW +: AW];
        s.wdata = m.wdata[i*DW +: DW];
        s.wmsk  = m.wmsk[i*MW +: MW];
        s.we    = m.we[i];
        own_cyc = m.cyc[i];
      end
    end
  end

  // An abort drops s_cyc in the same cycle because own_cyc is the live master request.
  always_comb begin
    s.cyc   = (state == ST_GRANT) && own_cyc;
    m.ack   = '0;
    m.rdata = s.rdata;
    if (state == ST_GRANT && s.ack[0]) begin
      m.ack[grant_id] = 1'b1;
    end
    if (state == ST_TERM) begin
      m.ack[grant_id] = 1'b1;
      m.rdata         = '1;
    end
  end

  assign wd_inc = wd + TO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      ptr      <= IW'(N - 1);
      wd       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_idx;
            wd       <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (wd != '1) begin
            wd <= wd_inc;
          end
          if (s.ack[0] || !own_cyc) begin
            state <= ST_IDLE;
            ptr   <= grant_id;
          end else if (wd_inc == '1) begin
            state <= ST_TERM;
          end
        end
        ST_TERM: begin
          state <= ST_IDLE;
          ptr   <= grant_id;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Setting has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (state == ST_TERM) begin
      timeout <= 1'b1;
    end else if (clr_timeout) begin
      timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (N=2, TO_W=4); inputs driven and outputs sampled on negedge.
module tb_wb_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_timeout = 1'b0;
  logic       timeout;
  logic [0:0] grant_id;

  int n_chk = 0;
  int n_fail = 0;
  int exp_g;

  wb_arbiter_rr_if #(.NM(2), .AW(16), .DW(32)) m_bus ();
  wb_arbiter_rr_if #(.NM(1), .AW(16), .DW(32)) s_bus ();

  wb_arbiter_rr #(.N(2), .AW(16), .DW(32), .TO_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m           (m_bus),
    .s           (s_bus),
    .timeout     (timeout),
    .clr_timeout (clr_timeout),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    m_bus.addr  = '0;
    m_bus.wdata = '0;
    m_bus.wmsk  = '0;
    m_bus.we    = '0;
    m_bus.cyc   = '0;
    s_bus.ack   = '0;
    s_bus.rdata = '0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_s_cyc", s_bus.cyc, 1'b0);
    chk("rst_m_ack", m_bus.ack, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    rst_n = 1'b1;

    // single read by master 0, slave acks two cycles into the grant
    @(negedge clk);
    m_bus.addr[15:0] = 16'h0010;
    m_bus.cyc = 2'b01;
    #1 chk("t1_s_cyc_before", s_bus.cyc, 1'b0);
    @(negedge clk);
    chk("t1_s_cyc", s_bus.cyc, 1'b1);
    chk("t1_s_addr", s_bus.addr, 16'h0010);
    chk("t1_grant", grant_id, 1'b0);
    chk("t1_no_ack", m_bus.ack, 2'b00);
    @(negedge clk);
    s_bus.ack = 1'b1;
    s_bus.rdata = 32'hCAFEF00D;
    #1 chk("t1_m_ack", m_bus.ack, 2'b01);
    chk("t1_m_rdata", m_bus.rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("t1_late_ack_idle", m_bus.ack, 2'b00);
    m_bus.cyc = 2'b00;
    s_bus.ack = 1'b0;

    // simultaneous request straight after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_bus.addr = {16'h0200, 16'h0100};
    m_bus.cyc = 2'b11;
    @(negedge clk);
    chk("t2_grant_first", grant_id, 1'b0);
    chk("t2_s_addr_first", s_bus.addr, 16'h0100);
    s_bus.ack = 1'b1;
    #1 chk("t2_ack_first", m_bus.ack, 2'b01);
    @(negedge clk);
    s_bus.ack = 1'b0;
    m_bus.cyc = 2'b10;
    #1 chk("t2_idle_gap", s_bus.cyc, 1'b0);
    @(negedge clk);
    chk("t2_grant_second", grant_id, 1'b1);
    chk("t2_s_addr_second", s_bus.addr, 16'h0200);
    chk("t2_s_cyc_second", s_bus.cyc, 1'b1);
    s_bus.ack = 1'b1;
    #1 chk("t2_ack_second", m_bus.ack, 2'b10);
    @(negedge clk);
    s_bus.ack = 1'b0;
    m_bus.cyc = 2'b00;

    // continuous requests alternate strictly
    @(negedge clk);
    m_bus.cyc = 2'b11;
    exp_g = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      m_bus.cyc = 2'b11;
      #1 chk("t3_grant", grant_id, exp_g[0]);
      chk("t3_s_cyc", s_bus.cyc, 1'b1);
      s_bus.ack = 1'b1;
      #1 chk("t3_ack", m_bus.ack, (exp_g == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      s_bus.ack = 1'b0;
      m_bus.cyc[exp_g] = 1'b0;
      #1 chk("t3_idle_gap", s_bus.cyc, 1'b0);
      exp_g = exp_g ^ 1;
    end
    m_bus.cyc = 2'b00;

    // hung slave: 15 granted cycles, then one terminating ack
    @(negedge clk);
    m_bus.addr[15:0] = 16'h0040;
    m_bus.cyc = 2'b01;
    s_bus.rdata = 32'h12345678;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("t4_wait_cyc_ack", {s_bus.cyc, m_bus.ack}, 3'b100);
    end
    @(negedge clk);
    chk("t4_term_s_cyc", s_bus.cyc, 1'b0);
    chk("t4_term_ack", m_bus.ack, 2'b01);
    chk("t4_term_rdata", m_bus.rdata, 32'hFFFFFFFF);
    clr_timeout = 1'b1;
    @(negedge clk);
    clr_timeout = 1'b0;
    m_bus.cyc = 2'b00;
    chk("t4_timeout_set_wins", timeout, 1'b1);
    chk("t4_no_ack_after_term", m_bus.ack, 2'b00);
    @(negedge clk);
    chk("t4_timeout_sticky", timeout, 1'b1);
    clr_timeout = 1'b1;
    @(negedge clk);
    clr_timeout = 1'b0;
    chk("t4_timeout_cleared", timeout, 1'b0);

    // master 1 aborts after three granted cycles, pending master 0 follows
    m_bus.addr = {16'h0500, 16'h0400};
    m_bus.cyc = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("t5_grant_m1", grant_id, 1'b1);
      chk("t5_s_cyc_m1", s_bus.cyc, 1'b1);
    end
    @(negedge clk);
    m_bus.cyc = 2'b01;
    #1 chk("t5_abort_same_cycle", s_bus.cyc, 1'b0);
    @(negedge clk);
    chk("t5_idle_s_cyc", s_bus.cyc, 1'b0);
    chk("t5_idle_no_ack", m_bus.ack, 2'b00);
    @(negedge clk);
    chk("t5_grant_m0", grant_id, 1'b0);
    chk("t5_s_addr_m0", s_bus.addr, 16'h0400);
    chk("t5_s_cyc_m0", s_bus.cyc, 1'b1);
    s_bus.ack = 1'b1;
    #1 chk("t5_ack_m0", m_bus.ack, 2'b01);
    @(negedge clk);
    s_bus.ack = 1'b0;
    m_bus.cyc = 2'b00;

    // asynchronous reset in the middle of a transfer
    @(negedge clk);
    m_bus.cyc = 2'b10;
    @(negedge clk);
    chk("t6_s_cyc_before", s_bus.cyc, 1'b1);
    chk("t6_grant_before", grant_id, 1'b1);
    s_bus.ack = 1'b1;
    #1 chk("t6_ack_before", m_bus.ack, 2'b10);
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_s_cyc", s_bus.cyc, 1'b0);
    chk("t6_rst_m_ack", m_bus.ack, 2'b00);
    chk("t6_rst_timeout", timeout, 1'b0);
    chk("t6_rst_grant", grant_id, 1'b0);
    s_bus.ack = 1'b0;
    m_bus.cyc = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_tie_grant", grant_id, 1'b0);
    chk("t6_tie_s_cyc", s_bus.cyc, 1'b1);
    chk("t6_tie_s_addr", s_bus.addr, 16'h0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
